// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and the status flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_ASR = 4'd10,
        OP_ROL = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic negative;
        logic zero;
        logic equal;
        logic less;
        logic div_zero;
        logic illegal;
    } alu_flags_t;

    // Opcodes 12..15 have no operation assigned.
    function automatic logic is_illegal(input logic [3:0] f_op);
        return f_op >= 4'd12;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: shift-add multiplier and restoring divider on one register pair.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;

    // r_hi holds the partial product / remainder, r_lo the multiplier / dividend-quotient.
    always_comb begin
        w_addend = r_lo[0] ? r_b : {WIDTH{1'b0}};
        w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
        w_trial  = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
        w_nhi    = w_sum[WIDTH:1];
        w_nlo    = {w_sum[0], r_lo[WIDTH-1:1]};
        if (r_div) begin
            // Top bit of the trial difference is the borrow: set means restore.
            if (!w_trial[WIDTH]) begin
                w_nhi = w_trial[WIDTH-1:0];
                w_nlo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_nhi = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                w_nlo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
        end else if (i_start) begin
            r_cnt <= CW'(WIDTH);
            r_div <= i_div;
            r_hi  <= '0;
            r_lo  <= i_a;
            r_b   <= i_b;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
        end
    end

    // The final step's value is handed out directly so the caller can register it on the last edge.
    assign o_done   = (r_cnt == CW'(1));
    assign o_result = {w_nhi, w_nlo};

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: valid/ready front end, one-cycle logic/shift ops, iterative MUL/DIV, registered flags.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               overflow,
    output logic               negative,
    output logic               zero,
    output logic               equal,
    output logic               less,
    output logic               div_zero,
    output logic               illegal,
    output state_e             o_dbg_state
);

    localparam int W2 = 2 * WIDTH;

    // Handshake: a request transfers on a rising edge where in_valid && in_ready; a result
    // transfers where out_valid && out_ready. in_ready and out_valid depend on state alone.

    state_e           r_state;
    state_e           w_next_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [W2-1:0]    r_result;
    alu_flags_t       r_flags;

    logic             w_accept;
    logic             w_is_iter;
    logic [W2-1:0]    w_single;
    alu_flags_t       w_single_flags;
    logic             w_iter_done;
    logic [W2-1:0]    w_iter_result;

    function automatic logic [W2-1:0] single_result(input logic [3:0] f_op,
                                                    input logic [WIDTH-1:0] f_a,
                                                    input logic [WIDTH-1:0] f_b);
        logic [W2-1:0]  res;
        logic [WIDTH:0] sum;
        res = '0;
        sum = {1'b0, f_a} + {1'b0, f_b};
        case (f_op)
            OP_ADD: res[WIDTH:0]   = sum;
            OP_SUB: res[WIDTH-1:0] = f_a - f_b;
            OP_DIV: res            = {f_a, {WIDTH{1'b1}}};
            OP_AND: res[WIDTH-1:0] = f_a & f_b;
            OP_OR:  res[WIDTH-1:0] = f_a | f_b;
            OP_XOR: res[WIDTH-1:0] = f_a ^ f_b;
            OP_NOT: res[WIDTH-1:0] = ~f_a;
            OP_SHL: res[WIDTH-1:0] = {f_a[WIDTH-2:0], 1'b0};
            OP_SHR: res[WIDTH-1:0] = {1'b0, f_a[WIDTH-1:1]};
            OP_ASR: res[WIDTH-1:0] = {f_a[WIDTH-1], f_a[WIDTH-1:1]};
            OP_ROL: res[WIDTH-1:0] = {f_a[WIDTH-2:0], f_a[WIDTH-1]};
            // MUL only lands here with b==0, whose product is zero; illegal ops also give zero.
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic alu_flags_t calc_flags(input logic [3:0] f_op,
                                              input logic [WIDTH-1:0] f_a,
                                              input logic [WIDTH-1:0] f_b,
                                              input logic [W2-1:0] f_res);
        alu_flags_t fl;
        fl = '0;
        case (f_op)
            OP_ADD: begin
                fl.carry    = f_res[WIDTH];
                fl.overflow = (f_a[WIDTH-1] == f_b[WIDTH-1]) && (f_res[WIDTH-1] != f_a[WIDTH-1]);
            end
            OP_SUB: begin
                fl.carry    = f_a < f_b;
                fl.overflow = (f_a[WIDTH-1] != f_b[WIDTH-1]) && (f_res[WIDTH-1] != f_a[WIDTH-1]);
            end
            OP_MUL:  fl.overflow = |f_res[W2-1:WIDTH];
            default: fl.overflow = 1'b0;
        endcase
        fl.negative = (f_op == OP_MUL) ? f_res[W2-1] : f_res[WIDTH-1];
        fl.zero     = (f_res == '0);
        fl.equal    = (f_a == f_b);
        fl.less     = (f_a < f_b);
        fl.div_zero = (f_op == OP_DIV) && (f_b == '0);
        fl.illegal  = is_illegal(f_op);
        return fl;
    endfunction

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept && w_is_iter),
        .i_div    (op == OP_DIV),
        .i_a      (a),
        .i_b      (b),
        .o_done   (w_iter_done),
        .o_result (w_iter_result)
    );

    always_comb begin
        w_accept       = in_valid && (r_state == IDLE);
        w_is_iter      = ((op == OP_MUL) || (op == OP_DIV)) && (b != '0);
        w_single       = single_result(op, a, b);
        w_single_flags = calc_flags(op, a, b, w_single);
        w_next_state   = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = w_is_iter ? BUSY : DONE;
            BUSY:    if (w_iter_done) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op <= op;
                r_a  <= a;
                r_b  <= b;
                if (!w_is_iter) begin
                    r_result <= w_single;
                    r_flags  <= w_single_flags;
                end
            end else if ((r_state == BUSY) && w_iter_done) begin
                r_result <= w_iter_result;
                r_flags  <= calc_flags(r_op, r_a, r_b, w_iter_result);
            end
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign result      = r_result;
    assign carry       = r_flags.carry;
    assign overflow    = r_flags.overflow;
    assign negative    = r_flags.negative;
    assign zero        = r_flags.zero;
    assign equal       = r_flags.equal;
    assign less        = r_flags.less;
    assign div_zero    = r_flags.div_zero;
    assign illegal     = r_flags.illegal;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed vector table, hold/reset sequences, random ops vs a model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [2*W-1:0] result;
    logic carry, overflow, negative, zero, equal, less, div_zero, illegal;
    state_e       dbg_state;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry       (carry),
        .overflow    (overflow),
        .negative    (negative),
        .zero        (zero),
        .equal       (equal),
        .less        (less),
        .div_zero    (div_zero),
        .illegal     (illegal),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dut_flags();
        return {carry, overflow, negative, zero, equal, less, div_zero, illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    // Flag byte order: carry, overflow, negative, zero, equal, less, div_zero, illegal.
    function automatic logic [23:0] model(input logic [3:0] m_op, input int ma, input int mb);
        int sa, sb, r;
        logic [15:0] res;
        logic c, o, n, dz, il;
        sa = (ma > 127) ? ma - 256 : ma;
        sb = (mb > 127) ? mb - 256 : mb;
        c = 0; o = 0; dz = 0; il = 0; res = 16'd0;
        case (m_op)
            4'd0: begin r = ma + mb; res = 16'(r); c = (r > 255); o = (sa + sb > 127) || (sa + sb < -128); end
            4'd1: begin res = 16'((ma - mb + 256) % 256); c = (ma < mb); o = (sa - sb > 127) || (sa - sb < -128); end
            4'd2: begin r = ma * mb; res = 16'(r); o = (r > 255); end
            4'd3: begin
                if (mb == 0) begin res = 16'(ma * 256 + 255); dz = 1; end
                else res = 16'((ma % mb) * 256 + ma / mb);
            end
            4'd4: res = 16'(ma & mb);
            4'd5: res = 16'(ma | mb);
            4'd6: res = 16'(ma ^ mb);
            4'd7: res = 16'(255 - ma);
            4'd8: res = 16'((ma * 2) % 256);
            4'd9: res = 16'(ma / 2);
            4'd10: res = 16'(ma / 2 + ((ma >= 128) ? 128 : 0));
            4'd11: res = 16'((ma * 2) % 256 + ma / 128);
            default: il = 1;
        endcase
        n = (m_op == 4'd2) ? (res >= 16'h8000) : ((res % 256) >= 128);
        return {res, c, o, n, (res == 16'd0), (ma == mb), (ma < mb), dz, il};
    endfunction

    function automatic int model_lat(input logic [3:0] m_op, input int mb);
        return ((m_op == 4'd2 || m_op == 4'd3) && mb != 0) ? W + 1 : 1;
    endfunction

    // driver: present one request, wait for the result; lat counts edges from request to out_valid
    task automatic run_op(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          output logic [15:0] res_o, output logic [7:0] fl_o, output int lat_o);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
        lat_o = 1;
        while (!out_valid && lat_o < 50) begin
            @(posedge clk); #1; lat_o++;
        end
        res_o = result;
        fl_o  = dut_flags();
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic [7:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [15:0] res;
        logic [7:0]  fl;
        logic [23:0] exp;
        int lat;
        int seen;

        vecs[0] = '{4'd0,  8'd200,  8'd100, 16'h012C, 8'h80, 1};
        vecs[1] = '{4'd1,  8'd5,    8'd9,   16'h00FC, 8'hA4, 1};
        vecs[2] = '{4'd2,  8'd255,  8'd255, 16'hFE01, 8'h68, 9};
        vecs[3] = '{4'd3,  8'd200,  8'd7,   16'h041C, 8'h00, 9};
        vecs[4] = '{4'd3,  8'd37,   8'd0,   16'h25FF, 8'h22, 1};
        vecs[5] = '{4'd10, 8'h96,   8'h00,  16'h00CB, 8'h20, 1};
        vecs[6] = '{4'd11, 8'h96,   8'h00,  16'h002D, 8'h00, 1};
        vecs[7] = '{4'd13, 8'h12,   8'h34,  16'h0000, 8'h15, 1};
        vecs[8] = '{4'd0,  8'd100,  8'd100, 16'h00C8, 8'h68, 1};
        vecs[9] = '{4'd1,  8'h80,   8'h01,  16'h007F, 8'h40, 1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'(dut_flags()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // out_ready while nothing is pending must be ignored
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_ready_ignored", 32'(in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, lat);
            chk($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_in_ready_done", i), 32'(in_ready), 32'd0);
            release_result();
        end

        // result held stable while the consumer stalls
        run_op(4'd1, 8'd5, 8'd9, res, fl, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_result", i), 32'(result), 32'h00FC);
            chk($sformatf("hold%0d_flags", i), 32'(dut_flags()), 32'hA4);
            chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d_out_valid", i), 32'(out_valid), 32'd1);
        end
        release_result();

        // reset three cycles into a MUL discards it
        op = 4'd2; a = 8'd255; b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midmul_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midmul_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midmul_no_result", 32'(seen), 32'd0);

        // random operations against the model, with random consumer stalls
        for (int i = 0; i < 150; i++) begin
            logic [3:0] r_op;
            logic [7:0] ra, rb;
            r_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) r_op = 4'($urandom_range(2, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            exp_q.push_back(model(r_op, int'(ra), int'(rb)));
            run_op(r_op, ra, rb, res, fl, lat);
            exp = exp_q.pop_front();
            chk($sformatf("rand%0d_op%0d_result", i, r_op), 32'(res), 32'(exp[23:8]));
            chk($sformatf("rand%0d_op%0d_flags", i, r_op), 32'(fl), 32'(exp[7:0]));
            chk($sformatf("rand%0d_op%0d_latency", i, r_op), 32'(lat), 32'(model_lat(r_op, int'(rb))));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            release_result();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, sequential successor to the team's 5-bit combinational ALU. Accepts one operation at a time over a valid/ready handshake. Single-cycle logic/shift operations complete in one cycle; multiply and divide run iteratively over WIDTH cycles. It returns a double-width result plus registered status flags, and sits between the decode stage and the writeback/flag register of the datapath.

## Interface
- WIDTH, 8: operand width in bits, valid range 4..32.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- op  in  4  opcode (alu_pkg::op_e).
- a, b  in  WIDTH  operands, unsigned unless noted.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  result word.
- carry, overflow, negative, zero, equal, less, div_zero, illegal  out  1 each  status flags.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV.
  - 4 AND, 5 OR, 6 XOR, 7 NOT a.
  - 8 SHL a by 1, 9 SHR a by 1 (logical), 10 ASR a by 1 (arithmetic, sign = a[WIDTH-1]), 11 ROL a by 1.
  - 12..15 illegal.
- Request accepted when in_valid && in_ready; a, b and op are captured in registers. Inputs are ignored otherwise.
- FSM states:
  - IDLE (in_ready=1): on accept of MUL/DIV with b!=0 go to BUSY; on any other accept go to DONE.
  - BUSY: the iteration counter counts WIDTH cycles, then the FSM goes to DONE.
  - DONE (out_valid=1): result and flags are held stable until out_ready, then the FSM goes to IDLE.
- Result packing:
  - Single-width ops: zero-extended into result[WIDTH-1:0].
  - ADD: {0, carry, sum}.
  - MUL: full 2*WIDTH unsigned product, shift-add.
  - DIV: {remainder, quotient}, restoring algorithm.
- DIV with b==0: takes the one-cycle path. quotient = all ones, remainder = a, div_zero=1.
- Illegal opcode: result 0, illegal=1, one-cycle path.
- Flags, registered at the same edge as result:
  - carry: ADD carry-out, or SUB borrow (a<b). 0 for all other ops.
  - overflow: signed overflow for ADD/SUB; for MUL, 1 when result[2W-1:W]!=0. 0 otherwise.
  - negative: MSB of the significant result (bit 2W-1 for MUL, else bit W-1).
  - zero: the full result == 0.
  - equal and less: a==b and unsigned a<b on the captured operands, valid for every op.

## Timing
- Reset: FSM=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, counter=0.
- Single-cycle ops: accept at edge k, out_valid=1 after edge k+1 (latency 1).
- MUL/DIV: accept at edge k, out_valid=1 after edge k+WIDTH+1.
- in_ready is combinational from state only (state==IDLE). There is no back-to-back accept in DONE, so throughput is at most one op per 2 cycles.
- out_valid high with out_ready low: everything is held indefinitely.
- out_ready high with out_valid low: ignored.
- rst_n asserted mid-BUSY or in DONE: the operation is discarded immediately and all outputs return to reset values. No partial result is ever presented.
- Counter width is $clog2(WIDTH+1). The counter never wraps, because it is reloaded on every accept.

## Structure
- alu_pkg holds the op_e enum (4-bit, values as above), the state_e enum (IDLE, BUSY, DONE) and the flag struct (alu_flags_t).
- Sub-module alu_iter_muldiv contains the shared shift-add multiplier / restoring divider datapath and counter, with start/done pulses. seq_alu holds the FSM, handshake, the single-cycle ops and the flags.

## Test plan
- WIDTH=8, ADD a=200, b=100 -> out_valid 1 cycle after accept; result=0x012C, carry=1, overflow=0, negative=0.
- SUB a=5, b=9 -> result=0x00FC, carry=1 (borrow), negative=1, less=1, equal=0.
- MUL a=255, b=255 -> out_valid exactly 9 cycles after accept; result=0xFE01, overflow=1, negative=1.
- DIV a=200, b=7 -> result={0x04,0x1C}. DIV a=37, b=0 -> 1-cycle latency, result={0x25,0xFF}, div_zero=1.
- ASR a=0x96 -> 0xCB; ROL a=0x96 -> 0x2D; op=13 -> result 0, illegal=1, zero=1.
- Hold out_ready low for 5 cycles in DONE -> result stable and in_ready=0. Assert rst_n low 3 cycles into a MUL -> out_valid=0 and in_ready=1 immediately, and no result appears afterwards.
